// File: rtl/hpm_event_unit.sv
// hpm_event_unit: holds the mhpmevent3..mhpmevent(COUNTERS-1) selector CSRs,
// aligns raw microarchitectural events to the M stage, and produces the
// per-counter increment vector CounterEvent for the counter CSR block.
// Optional build macro HPM_EVENT_OUTPUT_REG_EN registers CounterEvent
// (one extra cycle of latency; the inhibit mask is still applied live).
module hpm_event_unit #(
  parameter int XLEN       = 64,
  parameter int COUNTERS   = 32,
  parameter int NUM_EVENTS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                StallE,
  input  logic                StallM,
  input  logic                FlushM,
  input  logic                InstrValidNotFlushedM,
  input  logic                LoadStallD,
  input  logic                StoreStallD,
  input  logic                BPWrongM,
  input  logic [3:0]          IClassM,
  input  logic                DCacheAccess,
  input  logic                DCacheMiss,
  input  logic                ICacheAccess,
  input  logic                ICacheMiss,
  input  logic                DCacheStallM,
  input  logic                ICacheStallF,
  input  logic                InterruptM,
  input  logic                ExceptionM,
  input  logic                CSRMWriteM,
  input  logic [11:0]         CSRAdrM,
  input  logic [XLEN-1:0]     CSRWriteValM,
  input  logic [31:0]         MCOUNTINHIBIT_REGW,
  output logic [COUNTERS-1:0] CounterEvent,
  output logic [XLEN-1:0]     EventSelReadValM,
  output logic                EventSelHitM
);

  logic [4:0]          sel_q [COUNTERS];
  logic [4:0]          sel_d [COUNTERS];
  logic [4:0]          wr_code;
  logic [4:0]          rd_code;
  logic                load_stall_e_q, load_stall_e_d;
  logic                store_stall_e_q, store_stall_e_d;
  logic                load_stall_m_q, load_stall_m_d;
  logic                store_stall_m_q, store_stall_m_d;
  logic                dcache_stall_prev_q;
  logic [31:0]         raw_event;
  logic [COUNTERS-1:0] event_unmasked;
  logic [COUNTERS-1:0] event_out;

  // Upper write-data bits, return/call class bits and inhibit bits beyond
  // the implemented counters carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, IClassM[3:2], CSRWriteValM, MCOUNTINHIBIT_REGW};

  // WARL: codes outside the implemented event range collapse to "none".
  assign wr_code = ({1'b0, CSRWriteValM[4:0]} < 6'(NUM_EVENTS)) ? CSRWriteValM[4:0] : 5'd0;

  // Selector next state: only implemented counters 3..COUNTERS-1 accept writes.
  always_comb begin
    for (int i = 0; i < COUNTERS; i++) begin
      sel_d[i] = sel_q[i];
      if (i >= 3 && CSRMWriteM && CSRAdrM == 12'(32'h320 + i)) sel_d[i] = wr_code;
    end
  end

  // Selector registers; counters 0..2 are fixed-function and stay 0.
  always_ff @(posedge clk) begin
    for (int i = 0; i < COUNTERS; i++) sel_q[i] <= reset ? 5'd0 : sel_d[i];
  end

  // Stall pipeline next state: E holds under StallE, M clears on FlushM first.
  always_comb begin
    load_stall_e_d  = StallE ? load_stall_e_q  : LoadStallD;
    store_stall_e_d = StallE ? store_stall_e_q : StoreStallD;
    load_stall_m_d  = load_stall_m_q;
    store_stall_m_d = store_stall_m_q;
    if (FlushM) begin
      load_stall_m_d  = 1'b0;
      store_stall_m_d = 1'b0;
    end else if (!StallM) begin
      load_stall_m_d  = load_stall_e_q;
      store_stall_m_d = store_stall_e_q;
    end
  end

  // Stall pipeline registers and D$ stall history for episode edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_stall_e_q      <= 1'b0;
      store_stall_e_q     <= 1'b0;
      load_stall_m_q      <= 1'b0;
      store_stall_m_q     <= 1'b0;
      dcache_stall_prev_q <= 1'b0;
    end else begin
      load_stall_e_q      <= load_stall_e_d;
      store_stall_e_q     <= store_stall_e_d;
      load_stall_m_q      <= load_stall_m_d;
      store_stall_m_q     <= store_stall_m_d;
      dcache_stall_prev_q <= DCacheStallM;
    end
  end

  // Raw event table indexed by selector code; codes 16..31 are unassigned.
  always_comb begin
    raw_event     = '0;
    raw_event[1]  = load_stall_m_q;
    raw_event[2]  = store_stall_m_q;
    raw_event[3]  = BPWrongM & InstrValidNotFlushedM;
    raw_event[4]  = DCacheAccess;
    raw_event[5]  = DCacheMiss;
    raw_event[6]  = ICacheAccess;
    raw_event[7]  = ICacheMiss;
    raw_event[8]  = DCacheStallM;
    raw_event[9]  = ICacheStallF;
    raw_event[10] = InterruptM;
    raw_event[11] = ExceptionM;
    raw_event[12] = IClassM[0] & InstrValidNotFlushedM;
    raw_event[13] = IClassM[1] & InstrValidNotFlushedM;
    raw_event[14] = DCacheStallM & ~dcache_stall_prev_q;
    raw_event[15] = CSRMWriteM & InstrValidNotFlushedM;
  end

  // Per-counter increment before inhibit: cycle, reserved, instret, selected.
  always_comb begin
    event_unmasked = '0;
    event_unmasked[0] = 1'b1;
    event_unmasked[2] = InstrValidNotFlushedM;
    for (int i = 3; i < COUNTERS; i++) event_unmasked[i] = raw_event[sel_q[i]];
  end

`ifdef HPM_EVENT_OUTPUT_REG_EN
  logic [COUNTERS-1:0] event_q;

  // Output register, never stalled; inhibit is applied after it.
  always_ff @(posedge clk) begin
    event_q <= reset ? '0 : event_unmasked;
  end

  assign event_out = event_q;
`else
  assign event_out = event_unmasked;
`endif

  assign CounterEvent = reset ? '0 : (event_out & ~MCOUNTINHIBIT_REGW[COUNTERS-1:0]);

  // CSR read of the mhpmevent window; unimplemented selectors read 0.
  always_comb begin
    rd_code = 5'd0;
    if (EventSelHitM && !reset) begin
      for (int i = 3; i < COUNTERS; i++) begin
        if (CSRAdrM == 12'(32'h320 + i)) rd_code = sel_q[i];
      end
    end
  end

  assign EventSelHitM     = (CSRAdrM >= 12'h323) && (CSRAdrM <= 12'h33F);
  assign EventSelReadValM = {{(XLEN-5){1'b0}}, rd_code};

endmodule

// File: tb/tb_hpm_event_unit.sv
// Scoreboard bench for hpm_event_unit: the driver applies directed and random
// stimulus, predicts outputs with a reference model and queues them; the
// monitor compares DUT outputs against the queue every falling edge.
module tb_hpm_event_unit;
  localparam int XLEN = 64;
  localparam int CNT  = 20;
  localparam int NEV  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, StallE, StallM, FlushM, IVNF, LoadStallD, StoreStallD, BPWrongM;
  logic [3:0] IClassM;
  logic DCacheAccess, DCacheMiss, ICacheAccess, ICacheMiss, DCacheStallM, ICacheStallF;
  logic InterruptM, ExceptionM, CSRMWriteM;
  logic [11:0] CSRAdrM;
  logic [XLEN-1:0] CSRWriteValM;
  logic [31:0] Inhibit;
  logic [CNT-1:0] CounterEvent;
  logic [XLEN-1:0] EventSelReadValM;
  logic EventSelHitM;

  hpm_event_unit #(.XLEN(XLEN), .COUNTERS(CNT), .NUM_EVENTS(NEV)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .StallM(StallM), .FlushM(FlushM),
    .InstrValidNotFlushedM(IVNF), .LoadStallD(LoadStallD), .StoreStallD(StoreStallD),
    .BPWrongM(BPWrongM), .IClassM(IClassM), .DCacheAccess(DCacheAccess),
    .DCacheMiss(DCacheMiss), .ICacheAccess(ICacheAccess), .ICacheMiss(ICacheMiss),
    .DCacheStallM(DCacheStallM), .ICacheStallF(ICacheStallF), .InterruptM(InterruptM),
    .ExceptionM(ExceptionM), .CSRMWriteM(CSRMWriteM), .CSRAdrM(CSRAdrM),
    .CSRWriteValM(CSRWriteValM), .MCOUNTINHIBIT_REGW(Inhibit),
    .CounterEvent(CounterEvent), .EventSelReadValM(EventSelReadValM),
    .EventSelHitM(EventSelHitM)
  );

  typedef struct {
    logic [CNT-1:0]  ce;
    logic [XLEN-1:0] rd;
    logic            hit;
  } exp_t;
  exp_t sb[$];

  int compared = 0;
  int mismatched = 0;

  // Reference model state: selector contents and where each stall flag sits.
  int unsigned m_sel [32];
  bit m_ld_e, m_st_e, m_ld_m, m_st_m, m_dstall_prev;
  logic [CNT-1:0] m_prev_unmasked;

  function automatic bit evt(int unsigned code);
    case (code)
      1:  return m_ld_m;
      2:  return m_st_m;
      3:  return BPWrongM && IVNF;
      4:  return DCacheAccess;
      5:  return DCacheMiss;
      6:  return ICacheAccess;
      7:  return ICacheMiss;
      8:  return DCacheStallM;
      9:  return ICacheStallF;
      10: return InterruptM;
      11: return ExceptionM;
      12: return IClassM[0] && IVNF;
      13: return IClassM[1] && IVNF;
      14: return DCacheStallM && !m_dstall_prev;
      15: return CSRMWriteM && IVNF;
      default: return 1'b0;
    endcase
  endfunction

  // Predict this cycle's outputs, queue them, advance the model to the next edge.
  task automatic step();
    exp_t e;
    logic [CNT-1:0] unm;
    int unsigned idx;
    unm = '0;
    for (int i = 0; i < CNT; i++) begin
      if (i == 0) unm[i] = 1'b1;
      else if (i == 2) unm[i] = IVNF;
      else if (i >= 3) unm[i] = evt(m_sel[i]);
    end
`ifdef HPM_EVENT_OUTPUT_REG_EN
    e.ce = reset ? '0 : (m_prev_unmasked & ~Inhibit[CNT-1:0]);
`else
    e.ce = reset ? '0 : (unm & ~Inhibit[CNT-1:0]);
`endif
    e.hit = (CSRAdrM >= 12'h323) && (CSRAdrM <= 12'h33F);
    idx = 32'(CSRAdrM) - 32'h320;
    e.rd = (e.hit && !reset && idx < CNT) ? XLEN'(m_sel[idx]) : '0;
    sb.push_back(e);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_sel[i] = 0;
      {m_ld_e, m_st_e, m_ld_m, m_st_m, m_dstall_prev} = '0;
      m_prev_unmasked = '0;
    end else begin
      if (CSRMWriteM && CSRAdrM >= 12'h323 && idx < CNT)
        m_sel[idx] = (CSRWriteValM[4:0] < NEV) ? 32'(CSRWriteValM[4:0]) : 0;
      if (FlushM) begin m_ld_m = 0; m_st_m = 0; end
      else if (!StallM) begin m_ld_m = m_ld_e; m_st_m = m_st_e; end
      if (!StallE) begin m_ld_e = LoadStallD; m_st_e = StoreStallD; end
      m_dstall_prev = DCacheStallM;
      m_prev_unmasked = unm;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {StallE, StallM, FlushM, LoadStallD, StoreStallD, BPWrongM} = '0;
    {DCacheAccess, DCacheMiss, ICacheAccess, ICacheMiss, DCacheStallM, ICacheStallF} = '0;
    {InterruptM, ExceptionM, CSRMWriteM} = '0;
    IClassM = '0; IVNF = 1'b1; Inhibit = '0;
    CSRAdrM = 12'h000; CSRWriteValM = '0;
  endtask

  task automatic csr_wr(input logic [11:0] adr, input logic [XLEN-1:0] val);
    CSRMWriteM = 1'b1; CSRAdrM = adr; CSRWriteValM = val;
    step();
    CSRMWriteM = 1'b0;
  endtask

  // Monitor: compare whatever the DUT presents against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compared++;
        if (CounterEvent !== e.ce) begin
          mismatched++;
          $display("FAIL CounterEvent t=%0t got %h want %h", $time, CounterEvent, e.ce);
        end
        compared++;
        if (EventSelReadValM !== e.rd) begin
          mismatched++;
          $display("FAIL ReadVal adr=%h t=%0t got %h want %h", CSRAdrM, $time, EventSelReadValM, e.rd);
        end
        compared++;
        if (EventSelHitM !== e.hit) begin
          mismatched++;
          $display("FAIL Hit adr=%h t=%0t got %b want %b", CSRAdrM, $time, EventSelHitM, e.hit);
        end
      end
    end
  end

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    step(); step(); step();
    reset = 1'b0;
    // Idle after reset: only cycle and instret counters tick.
    step(); step();
    CSRAdrM = 12'h323; step();
    // Select D$ miss on counter 3 and pulse it once.
    csr_wr(12'h323, 64'd5);
    CSRAdrM = 12'h323; DCacheMiss = 1'b1; step();
    DCacheMiss = 1'b0; step();
    // WARL and unimplemented selector writes.
    csr_wr(12'h324, 64'h1F);
    CSRAdrM = 12'h324; step();
    csr_wr(12'h33F, 64'd1);
    CSRAdrM = 12'h33F; step();
    // Load stall travels D -> E -> M, then the same with a flush in between.
    csr_wr(12'h324, 64'd1);
    LoadStallD = 1'b1; step();
    LoadStallD = 1'b0; step(); step(); step();
    LoadStallD = 1'b1; step();
    LoadStallD = 1'b0; FlushM = 1'b1; step();
    FlushM = 1'b0; step(); step();
    // D$ stall episode vs stall cycles.
    csr_wr(12'h325, 64'd14);
    csr_wr(12'h326, 64'd8);
    DCacheStallM = 1'b1;
    for (int i = 0; i < 6; i++) step();
    DCacheStallM = 1'b0; step();
    // Inhibit on counter 3 with D$ access selected.
    csr_wr(12'h323, 64'd4);
    DCacheAccess = 1'b1; Inhibit = 32'h8; step(); step();
    Inhibit = 32'h0; step(); step();
    DCacheAccess = 1'b0; step(); step();
    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 199) == 0);
      StallE       = ($urandom_range(0, 3) == 0);
      StallM       = ($urandom_range(0, 3) == 0);
      FlushM       = ($urandom_range(0, 5) == 0);
      IVNF         = $urandom_range(0, 1);
      LoadStallD   = $urandom_range(0, 1);
      StoreStallD  = $urandom_range(0, 1);
      BPWrongM     = $urandom_range(0, 1);
      IClassM      = 4'($urandom);
      DCacheAccess = $urandom_range(0, 1);
      DCacheMiss   = $urandom_range(0, 1);
      ICacheAccess = $urandom_range(0, 1);
      ICacheMiss   = $urandom_range(0, 1);
      DCacheStallM = ($urandom_range(0, 2) != 0);
      ICacheStallF = $urandom_range(0, 1);
      InterruptM   = $urandom_range(0, 1);
      ExceptionM   = $urandom_range(0, 1);
      CSRMWriteM   = ($urandom_range(0, 2) == 0);
      CSRAdrM      = 12'($urandom_range(32'h31E, 32'h341));
      CSRWriteValM = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 1) == 1) CSRWriteValM = 64'($urandom_range(0, 20));
      Inhibit      = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'h0;
      step();
    end
    reset = 1'b0;
    idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain left %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/hpm_event_unit.md
Name: hpm_event_unit

Overview:
- Upstream feeder for the counter CSR block. Holds the mhpmevent3..31 selector CSRs and pipelines raw microarchitectural events from the D/E stages to M.
- Produces the per-counter increment vector CounterEvent[COUNTERS-1:0] consumed by the counter CSR block.
- Also answers CSR reads of the mhpmevent range, so the counter block only handles counter registers.

Parameters:
- XLEN, 64, CSR data width (32 or 64)
- COUNTERS, 32, number of implemented counters (3..32)
- NUM_EVENTS, 16, number of selectable event codes (power of 2, ≤32)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- StallE, StallM  in  1  pipeline stalls
- FlushM  in  1  flush of M stage
- InstrValidNotFlushedM  in  1  instruction retiring in M
- LoadStallD, StoreStallD  in  1  load-use / store stall detected in D
- BPWrongM  in  1  branch predictor wrong
- IClassM  in  4  instruction class {ret,call,jump,branch}
- DCacheAccess, DCacheMiss, ICacheAccess, ICacheMiss  in  1  cache events
- DCacheStallM, ICacheStallF  in  1  cache stall cycles
- InterruptM, ExceptionM  in  1  trap events
- CSRMWriteM  in  1  machine CSR write
- CSRAdrM  in  12  CSR address
- CSRWriteValM  in  XLEN  write data
- MCOUNTINHIBIT_REGW  in  32  counter inhibit
- CounterEvent  out  COUNTERS  increment request per counter
- EventSelReadValM  out  XLEN  read value of addressed mhpmevent
- EventSelHitM  out  1  CSRAdrM within 0x323..0x33F

Behaviour:
- Selector CSRs:
  - mhpmeventN (N=3..COUNTERS-1) at 0x320+N holds a 5-bit code in bits [4:0]. Other bits read 0.
  - Write when CSRMWriteM & CSRAdrM==0x320+N.
  - WARL: a written code ≥NUM_EVENTS stores 0.
  - Addresses for N≥COUNTERS within 0x323..0x33F read 0 and ignore writes.
  - Selectors reset to 0. A write in cycle T affects CounterEvent from cycle T+1.
- Read path: EventSelHitM = (0x323≤CSRAdrM≤0x33F). EventSelReadValM = zero-extended selector when hit, else 0. Combinational; 0 during reset.
- Stall pipeline:
  - LoadStallE/StoreStallE enabled by ~StallE, never cleared.
  - LoadStallM/StoreStallM enabled by ~StallM, cleared by FlushM. FlushM has priority over the enable.
  - All reset to 0.
- Miss-episode edge: register DCacheStallPrev (resets to 0). Episode event = DCacheStallM & ~DCacheStallPrev.
- Event codes (RawEvent):
  - 0 none
  - 1 LoadStallM
  - 2 StoreStallM
  - 3 BPWrongM & InstrValidNotFlushedM
  - 4 DCacheAccess
  - 5 DCacheMiss
  - 6 ICacheAccess
  - 7 ICacheMiss
  - 8 DCacheStallM
  - 9 ICacheStallF
  - 10 InterruptM
  - 11 ExceptionM
  - 12 IClassM[0] & InstrValidNotFlushedM
  - 13 IClassM[1] & InstrValidNotFlushedM
  - 14 D$ miss episode
  - 15 CSRMWriteM & InstrValidNotFlushedM
  - Codes 16..31 (if NUM_EVENTS=32): 0.
- CounterEvent:
  - [0] = 1; [1] = 0; [2] = InstrValidNotFlushedM.
  - [i≥3] = RawEvent[sel_i].
  - Every bit is ANDed with ~MCOUNTINHIBIT_REGW[i].
  - Combinational by default (0 latency from M-stage event to output).
- Reset: CounterEvent is 0 while reset is asserted (all bits, including [0]).
- Simultaneous selector write and event in the same cycle: the old selector applies that cycle.
- A stall does not freeze selectors; events are sampled every cycle.

Optional Feature:
- Macro HPM_EVENT_OUTPUT_REG_EN.
- Defined: CounterEvent is registered, adding 1 cycle of latency.
  - The register resets to 0 and is not stalled.
  - The inhibit mask is applied after the register, using the current MCOUNTINHIBIT_REGW, so an inhibit takes effect immediately.
- Undefined: purely combinational output as described above.

Test Plan:
- Reset, then release with no CSR writes -> CounterEvent = 0x5 (bits 0,2 only when InstrValidNotFlushedM=1); all selectors read 0.
- Write 0x323 ← 5, then pulse DCacheMiss for 1 cycle -> CounterEvent[3]=1 exactly that cycle; read of 0x323 returns 5.
- Write 0x324 ← 0x1F with NUM_EVENTS=16 -> reads 0; write 0x33F ← 1 with COUNTERS=16 -> reads 0, no effect on outputs.
- Set sel4=1, LoadStallD=1 for 1 cycle, no stalls -> CounterEvent[4]=1 two cycles later. Repeat with FlushM asserted when the stall reaches M -> CounterEvent[4] stays 0.
- Set sel5=14, DCacheStallM high for 6 cycles -> CounterEvent[5] pulses once at the first cycle. Set sel6=8 with the same stimulus -> CounterEvent[6] high for 6 cycles.
- MCOUNTINHIBIT_REGW=0x8 with sel3=4 and DCacheAccess=1 -> CounterEvent[3]=0. With HPM_EVENT_OUTPUT_REG_EN defined, uninhibited -> pulse appears 1 cycle later.
